bfp_load_buffer: RTL and testbench



---
 rtl/bfp_load_buffer.sv | 115 +++++++++++
 tb/tb_bfp_load_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_load_buffer.sv
// bfp_load_buffer
//   Assembles block-floating-point groups from AXI read-data beats and
//   ping-pongs them between two banks toward the PE activation broadcast.
//   A group is MANT_BEATS beats of packed mantissas followed by one beat
//   whose low EXP_WIDTH bits carry the shared exponent.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         synchronous clear of pointers/valids (bank data kept)
//   rvalid_i/rready_o, rdata_i, rlast_i   AXI R-channel beat handshake
//   out_valid_o/out_ready_i               group handshake toward the PEs
//   out_mantissa_o  mantissa i at [i*MANT_WIDTH +: MANT_WIDTH]
//   out_exponent_o  shared exponent of the presented group
//   occupancy_o     committed groups currently held (0..2)
//   len_err_o       one-cycle pulse when rlast_i disagrees with the group length
module bfp_load_buffer #(
    parameter int unsigned AXI_WIDTH_DA = 32,
    parameter int unsigned MANT_WIDTH   = 7,
    parameter int unsigned EXP_WIDTH    = 8,
    parameter int unsigned NUM_MANT     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           rvalid_i,
    input  logic [AXI_WIDTH_DA-1:0]        rdata_i,
    input  logic                           rlast_i,
    output logic                           rready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_MANT*MANT_WIDTH-1:0] out_mantissa_o,
    output logic [EXP_WIDTH-1:0]           out_exponent_o,
    output logic [1:0]                     occupancy_o,
    output logic                           len_err_o
);

    localparam int unsigned MANT_BITS  = NUM_MANT * MANT_WIDTH;
    localparam int unsigned MANT_BEATS = (MANT_BITS + AXI_WIDTH_DA - 1) / AXI_WIDTH_DA;
    localparam int unsigned BEATS      = MANT_BEATS + 1;
    localparam int unsigned PACK_BITS  = MANT_BEATS * AXI_WIDTH_DA;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Banks hold whole beats; padding past MANT_BITS is never presented.
    logic [PACK_BITS-1:0] bank_mant [2];
    logic [EXP_WIDTH-1:0] bank_exp  [2];
    logic [1:0]           bank_valid;
    logic [1:0]           bank_valid_nxt;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 len_err_q;

    logic beat_acc;
    logic last_slot;
    logic commit;
    logic drain;
    logic len_err_nxt;

    assign rready_o       = rst_n && !bank_valid[wr_ptr];
    assign out_valid_o    = bank_valid[rd_ptr];
    assign out_mantissa_o = bank_mant[rd_ptr][MANT_BITS-1:0];
    assign out_exponent_o = bank_exp[rd_ptr];
    assign occupancy_o    = {1'b0, bank_valid[0]} + {1'b0, bank_valid[1]};
    assign len_err_o      = len_err_q;

    always_comb begin
        beat_acc  = rvalid_i && rready_o;
        last_slot = (beat_cnt == LAST_BEAT);
        commit    = beat_acc && last_slot;
        drain     = out_valid_o && out_ready_i;
        // Early rlast aborts the group; a missing rlast still commits it.
        len_err_nxt = (beat_acc && !last_slot && rlast_i) || (commit && !rlast_i);

        // Commit and drain always target different banks, so both apply.
        bank_valid_nxt = bank_valid;
        if (commit) bank_valid_nxt[wr_ptr] = 1'b1;
        if (drain)  bank_valid_nxt[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            bank_valid <= '0;
            len_err_q  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                bank_mant[i] <= '0;
                bank_exp[i]  <= '0;
            end
        end else if (flush_i) begin
            beat_cnt   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            bank_valid <= '0;
            len_err_q  <= 1'b0;
        end else begin
            bank_valid <= bank_valid_nxt;
            len_err_q  <= len_err_nxt;
            if (drain) rd_ptr <= ~rd_ptr;
            if (beat_acc) begin
                if (last_slot) begin
                    bank_exp[wr_ptr] <= rdata_i[EXP_WIDTH-1:0];
                    wr_ptr           <= ~wr_ptr;
                    beat_cnt         <= '0;
                end else begin
                    bank_mant[wr_ptr][int'(beat_cnt) * AXI_WIDTH_DA +: AXI_WIDTH_DA] <= rdata_i;
                    beat_cnt <= rlast_i ? '0 : beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfp_load_buffer.sv
// tb_bfp_load_buffer
//   Randomised and directed stimulus for bfp_load_buffer. A group-level
//   reference model (queue of held groups, list of collected beats) runs at
//   the falling edge; expected groups are queued when the model commits them
//   and popped when the output handshake fires.
module tb_bfp_load_buffer;

    localparam int AXI   = 32;
    localparam int MW    = 7;
    localparam int EW    = 8;
    localparam int NM    = 32;
    localparam int MBITS = NM * MW;
    localparam int MB    = (MBITS + AXI - 1) / AXI;
    localparam int BEATS = MB + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             rvalid_i;
    logic [AXI-1:0]   rdata_i;
    logic             rlast_i;
    logic             rready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [MBITS-1:0] out_mantissa_o;
    logic [EW-1:0]    out_exponent_o;
    logic [1:0]       occupancy_o;
    logic             len_err_o;

    bfp_load_buffer #(
        .AXI_WIDTH_DA(AXI),
        .MANT_WIDTH  (MW),
        .EXP_WIDTH   (EW),
        .NUM_MANT    (NM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i),
        .rlast_i       (rlast_i),
        .rready_o      (rready_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_mantissa_o(out_mantissa_o),
        .out_exponent_o(out_exponent_o),
        .occupancy_o   (occupancy_o),
        .len_err_o     (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MBITS-1:0] m;
        logic [EW-1:0]    e;
    } grp_t;

    grp_t           held_q[$];
    logic [AXI-1:0] beat_q[$];
    bit             err_exp  = 1'b0;
    bit             model_ok = 1'b0;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_out    = 0;
    logic [AXI-1:0] words[BEATS];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mantissa beats concatenate little-endian; the exponent is the low byte
    // of the final beat.
    function automatic grp_t make_group();
        grp_t             g;
        logic [MB*AXI-1:0] acc;
        logic [AXI-1:0]    ew;
        acc = '0;
        for (int i = 0; i < MB; i++) acc = acc | ((MB*AXI)'(beat_q[i]) << (i * AXI));
        ew  = beat_q[BEATS-1];
        g.m = acc[MBITS-1:0];
        g.e = ew[EW-1:0];
        return g;
    endfunction

    // Monitor / scoreboard: compare the current state, then advance the model
    // by the clock edge that follows.
    always @(negedge clk) begin
        bit acc;
        bit drn;
        if (!rst_n) check("rready_in_reset", rready_o, 0);
        else if (model_ok) check("rready", rready_o, held_q.size() < 2);
        if (model_ok) begin
            check("occupancy", occupancy_o, held_q.size());
            check("out_valid", out_valid_o, held_q.size() > 0);
            check("len_err", len_err_o, err_exp);
            if (held_q.size() > 0) begin
                check("mantissa", out_mantissa_o, held_q[0].m);
                check("exponent", out_exponent_o, held_q[0].e);
            end
        end
        if (!rst_n || flush_i) begin
            held_q.delete();
            beat_q.delete();
            err_exp  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = rvalid_i && (held_q.size() < 2);
            drn = (held_q.size() > 0) && out_ready_i;
            err_exp = 1'b0;
            if (drn) begin
                void'(held_q.pop_front());
                n_out++;
            end
            if (acc) begin
                beat_q.push_back(rdata_i);
                if (beat_q.size() == BEATS) begin
                    held_q.push_back(make_group());
                    if (!rlast_i) err_exp = 1'b1;
                    beat_q.delete();
                end else if (rlast_i) begin
                    beat_q.delete();
                    err_exp = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [AXI-1:0] d, input bit last);
        int waited = 0;
        bit acc = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = d;
        rlast_i  = last;
        while (!acc && waited <= 300) begin
            @(negedge clk);
            acc = rready_o;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: got no acceptance expected acceptance within 300 cycles");
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
    endtask

    task automatic send_burst(input int n, input int last_at, input int gap_max);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gap_max, 0)) cycles(1);
            drive_beat(words[k], k == last_at);
        end
    endtask

    task automatic fill_words(input bit directed);
        for (int k = 0; k < MB; k++) begin
            if (directed) words[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            else          words[k] = $urandom;
        end
        words[BEATS-1] = directed ? 32'h0000_007F : $urandom;
    endtask

    task automatic wait_drain();
        int waited = 0;
        out_ready_i = 1'b1;
        while (held_q.size() > 0 && waited < 100) begin
            cycles(1);
            waited++;
        end
        if (held_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d groups held expected 0", held_q.size());
        end
        out_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        bit done;
        rst_n = 1'b0; flush_i = 1'b0; rvalid_i = 1'b0;
        rdata_i = '0; rlast_i = 1'b0; out_ready_i = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        check("rst_mantissa", out_mantissa_o, 0);
        check("rst_exponent", out_exponent_o, 0);
        check("rst_occupancy", occupancy_o, 0);
        check("rst_out_valid", out_valid_o, 0);

        // Directed first group; out_valid must be high right after the last beat.
        fill_words(1'b1);
        send_burst(BEATS, BEATS-1, 0);
        check("t1_valid", out_valid_o, 1);
        check("t1_mant0", out_mantissa_o[MW-1:0], 7'h00);
        check("t1_mant1", out_mantissa_o[2*MW-1:MW], 7'h02);
        check("t1_exp", out_exponent_o, 8'h7F);
        check("t1_occ", occupancy_o, 1);
        wait_drain();

        // Fill both banks, then stall group 3 until a single-cycle drain.
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        check("t2_full_occ", occupancy_o, 2);
        check("t2_full_rready", rready_o, 0);
        fork
            begin
                fill_words(1'b0);
                send_burst(BEATS, BEATS-1, 0);
            end
            begin
                cycles(4);
                out_ready_i = 1'b1;
                cycles(1);
                out_ready_i = 1'b0;
                check("t2_rready_reopen", rready_o, 1);
            end
        join
        check("t2_occ_after", occupancy_o, 2);
        wait_drain();

        // Early rlast: abort with one error pulse, then a clean group.
        fill_words(1'b0);
        send_burst(5, 4, 0);
        check("t3_len_err", len_err_o, 1);
        check("t3_occ", occupancy_o, 0);
        cycles(1);
        check("t3_len_err_clear", len_err_o, 0);
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        wait_drain();

        // Missing rlast: group still commits, error pulses.
        fill_words(1'b0);
        send_burst(BEATS, -1, 0);
        check("t4_len_err", len_err_o, 1);
        check("t4_occ", occupancy_o, 1);
        wait_drain();

        // Streaming with the consumer always ready.
        out_ready_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            fill_words(1'b0);
            send_burst(BEATS, BEATS-1, 0);
        end
        wait_drain();

        // Flush mid-burst with a group held.
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        fill_words(1'b0); send_burst(3, -1, 0);
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        check("t6_flush_occ", occupancy_o, 0);
        check("t6_flush_valid", out_valid_o, 0);
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        wait_drain();

        // Reset mid-burst with a group held: outputs return to zero.
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        fill_words(1'b0); send_burst(3, -1, 0);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("t6_rst_occ", occupancy_o, 0);
        check("t6_rst_valid", out_valid_o, 0);
        check("t6_rst_mant", out_mantissa_o, 0);
        check("t6_rst_exp", out_exponent_o, 0);
        fill_words(1'b0); send_burst(BEATS, BEATS-1, 0);
        wait_drain();

        // Random traffic: gaps, consumer back-pressure, occasional bad lengths.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    int r;
                    fill_words(1'b0);
                    r = $urandom_range(9, 0);
                    if (r == 0) begin
                        int len;
                        len = $urandom_range(BEATS-1, 1);
                        send_burst(len, len-1, 2);
                    end else if (r == 1) begin
                        send_burst(BEATS, -1, 2);
                    end else begin
                        send_burst(BEATS, BEATS-1, 2);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready_i = 1'($urandom_range(1, 0));
                    cycles(1);
                end
            end
        join
        wait_drain();
        cycles(2);
        check("groups_emitted_nonzero", n_out > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
